// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the NoC flit splitter and the packet assembler.
// Provides the derived-width helpers (flit count, sequence width, mesh
// address width, flit width), a generic flit field extractor and the
// node-index to mesh-address encoder.
// Flit layout, MSB to LSB: {vld, dest, data, id, src, seq}.
package noc_pkg;

    // Widest flit any instance is expected to carry; field extraction works on
    // a zero-extended copy of this width.
    localparam int FLIT_MAX_W = 128;

    function automatic int flit_count_f(input int payload, input int flit_payload);
        return (payload + flit_payload - 1) / flit_payload;
    endfunction

    // A single-flit packet still carries a 1-bit sequence field.
    function automatic int seq_w_f(input int flit_count);
        return (flit_count <= 1) ? 1 : $clog2(flit_count);
    endfunction

    function automatic int addr_w_f(input int x, input int y);
        return $clog2(x) + $clog2(y);
    endfunction

    function automatic int flit_w_f(input int payload, input int flit_payload, input int id_w,
                                    input int node_w, input int x, input int y);
        return 1 + addr_w_f(x, y) + flit_payload + id_w + node_w
                 + seq_w_f(flit_count_f(payload, flit_payload));
    endfunction

    // Returns bits [lsb +: width] of a flit, zero-extended to FLIT_MAX_W.
    function automatic logic [FLIT_MAX_W-1:0] field_f(input logic [FLIT_MAX_W-1:0] flit,
                                                      input int lsb, input int width);
        logic [FLIT_MAX_W-1:0] mask;
        if (width >= FLIT_MAX_W) begin
            mask = {FLIT_MAX_W{1'b1}};
        end else begin
            mask = (FLIT_MAX_W'(1) << width) - FLIT_MAX_W'(1);
        end
        return (flit >> lsb) & mask;
    endfunction

    // Mesh address {column, row}: column = node % X, row = node / X.
    function automatic int node_addr_f(input int node_id, input int x, input int y);
        return ((node_id % x) << $clog2(y)) | (node_id / x);
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// packet_fifo: synchronous FIFO of completed packets.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push_i       write wr_data_i (accepted when not full, or when popping in the same cycle)
//   pop_i        discard the head entry (ignored when empty)
//   wr_data_i    entry to write
//   rd_data_o    head entry, read straight from the storage registers
//   full_o       DEPTH entries held
//   empty_o      no entries held
module packet_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign rd_data_o = mem_q[rd_ptr_q];
    // When full, the write lands in the slot the simultaneous pop frees.
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Next-state pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// packet_assembler: reassembles flits from the router ejection port into
// PAYLOAD-bit packets, one reassembly slot per source node, and queues the
// completed packets for the core.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ce              clock enable; low freezes all state and ignores flits
//   flit_in         {vld, dest, data, id, src, seq}; flit_valid qualifies it
//   packet_out, src_out, id_out, out_valid / out_ready   completed-packet FIFO head
//   drop_*          one-cycle pulses for misrouted, malformed, restarted and overflowed packets
module packet_assembler
    import noc_pkg::*;
#(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int QUEUE_DEPTH     = 8,
    parameter int PAYLOAD         = 32,
    parameter int FLIT_PAYLOAD    = 8,
    parameter int X               = 3,
    parameter int Y               = 3,
    localparam int NODE_W     = $clog2(NODE_COUNT),
    localparam int FLIT_COUNT = flit_count_f(PAYLOAD, FLIT_PAYLOAD),
    localparam int SEQ_W      = seq_w_f(FLIT_COUNT),
    localparam int ADDR_W     = addr_w_f(X, Y),
    localparam int FLIT_W     = flit_w_f(PAYLOAD, FLIT_PAYLOAD, PACKET_ID_WIDTH, NODE_W, X, Y)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [FLIT_W-1:0]          flit_in,
    input  logic                       flit_valid,
    output logic [PAYLOAD-1:0]         packet_out,
    output logic [NODE_W-1:0]          src_out,
    output logic [PACKET_ID_WIDTH-1:0] id_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       drop_misroute,
    output logic                       drop_malformed,
    output logic                       drop_restart,
    output logic                       drop_overflow
);

    localparam int SEQ_LSB  = 0;
    localparam int SRC_LSB  = SEQ_LSB + SEQ_W;
    localparam int ID_LSB   = SRC_LSB + NODE_W;
    localparam int DATA_LSB = ID_LSB + PACKET_ID_WIDTH;
    localparam int DEST_LSB = DATA_LSB + FLIT_PAYLOAD;
    localparam int VLD_LSB  = DEST_LSB + ADDR_W;
    localparam int ENTRY_W  = PAYLOAD + NODE_W + PACKET_ID_WIDTH;
    localparam logic [ADDR_W-1:0] OWN_ADDR = ADDR_W'(node_addr_f(NODE_ID, X, Y));

    // Flit fields
    logic [FLIT_MAX_W-1:0]      flit_ext_s;
    logic                       flit_vld_s;
    logic [ADDR_W-1:0]          flit_dest_s;
    logic [FLIT_PAYLOAD-1:0]    flit_data_s;
    logic [PACKET_ID_WIDTH-1:0] flit_id_s;
    logic [NODE_W-1:0]          flit_src_s;
    logic [SEQ_W-1:0]           flit_seq_s;
    logic                       seq_bad_s, src_bad_s;

    // Reassembly slots, one per source
    logic [FLIT_COUNT-1:0][FLIT_PAYLOAD-1:0] slot_data_q [NODE_COUNT];
    logic [PACKET_ID_WIDTH-1:0]              slot_id_q   [NODE_COUNT];
    logic [FLIT_COUNT-1:0]                   slot_mask_q [NODE_COUNT];
    logic [NODE_COUNT-1:0]                   slot_busy_q;

    logic [FLIT_COUNT-1:0][FLIT_PAYLOAD-1:0] merged_data_d;
    logic [FLIT_COUNT-1:0]                   new_mask_d;
    logic take_s, accept_s, same_pkt_s, complete_s, pop_s;
    logic misroute_d, malformed_d, restart_d, overflow_d;
    logic drop_misroute_q, drop_malformed_q, drop_restart_q, drop_overflow_q;

    logic               fifo_push_s, fifo_full_s, fifo_empty_s;
    logic [ENTRY_W-1:0] fifo_wr_data_s, fifo_rd_data_s;

    assign flit_ext_s  = FLIT_MAX_W'(flit_in);
    assign flit_vld_s  = 1'(field_f(flit_ext_s, VLD_LSB, 1));
    assign flit_dest_s = ADDR_W'(field_f(flit_ext_s, DEST_LSB, ADDR_W));
    assign flit_data_s = FLIT_PAYLOAD'(field_f(flit_ext_s, DATA_LSB, FLIT_PAYLOAD));
    assign flit_id_s   = PACKET_ID_WIDTH'(field_f(flit_ext_s, ID_LSB, PACKET_ID_WIDTH));
    assign flit_src_s  = NODE_W'(field_f(flit_ext_s, SRC_LSB, NODE_W));
    assign flit_seq_s  = SEQ_W'(field_f(flit_ext_s, SEQ_LSB, SEQ_W));
    // Range checks on the zero-extended fields so they stay meaningful for any width.
    assign seq_bad_s   = field_f(flit_ext_s, SEQ_LSB, SEQ_W) >= FLIT_MAX_W'(FLIT_COUNT);
    assign src_bad_s   = field_f(flit_ext_s, SRC_LSB, NODE_W) >= FLIT_MAX_W'(NODE_COUNT);

    assign pop_s = ce & out_valid & out_ready;

    // Flit classification, slot merge and completion decision.
    always_comb begin
        take_s        = ce & flit_valid & flit_vld_s;
        misroute_d    = 1'b0;
        malformed_d   = 1'b0;
        accept_s      = 1'b0;
        same_pkt_s    = slot_busy_q[flit_src_s] & (slot_id_q[flit_src_s] == flit_id_s);
        merged_data_d = slot_data_q[flit_src_s];
        new_mask_d    = {FLIT_COUNT{1'b0}};
        if (take_s && (flit_dest_s != OWN_ADDR)) begin
            misroute_d = 1'b1;
        end else if (take_s && (seq_bad_s || src_bad_s)) begin
            malformed_d = 1'b1;
        end else begin
            accept_s = take_s;
        end
        if (accept_s) begin
            merged_data_d[flit_seq_s] = flit_data_s;
        end else begin
            merged_data_d = slot_data_q[flit_src_s];
        end
        // A new or restarted packet starts from an empty mask.
        if (same_pkt_s) begin
            new_mask_d = slot_mask_q[flit_src_s] | (FLIT_COUNT'(1) << flit_seq_s);
        end else begin
            new_mask_d = FLIT_COUNT'(1) << flit_seq_s;
        end
        restart_d   = accept_s & slot_busy_q[flit_src_s] & ~same_pkt_s;
        complete_s  = accept_s & (&new_mask_d);
        fifo_push_s = complete_s & (~fifo_full_s | pop_s);
        overflow_d  = complete_s & fifo_full_s & ~pop_s;
    end

    assign fifo_wr_data_s = {PAYLOAD'(merged_data_d), flit_src_s, flit_id_s};

    // Slot state: a completing flit (pushed or overflowed) frees its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                slot_data_q[i] <= {(FLIT_COUNT*FLIT_PAYLOAD){1'b0}};
                slot_id_q[i]   <= {PACKET_ID_WIDTH{1'b0}};
                slot_mask_q[i] <= {FLIT_COUNT{1'b0}};
            end
            slot_busy_q <= {NODE_COUNT{1'b0}};
        end else if (accept_s) begin
            slot_data_q[flit_src_s] <= merged_data_d;
            slot_id_q[flit_src_s]   <= flit_id_s;
            slot_mask_q[flit_src_s] <= complete_s ? {FLIT_COUNT{1'b0}} : new_mask_d;
            slot_busy_q[flit_src_s] <= ~complete_s;
        end
    end

    // Drop pulses; each _d already includes ce, so they read zero while ce is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_misroute_q  <= 1'b0;
            drop_malformed_q <= 1'b0;
            drop_restart_q   <= 1'b0;
            drop_overflow_q  <= 1'b0;
        end else begin
            drop_misroute_q  <= misroute_d;
            drop_malformed_q <= malformed_d;
            drop_restart_q   <= restart_d;
            drop_overflow_q  <= overflow_d;
        end
    end

    assign drop_misroute  = drop_misroute_q;
    assign drop_malformed = drop_malformed_q;
    assign drop_restart   = drop_restart_q;
    assign drop_overflow  = drop_overflow_q;

    packet_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (fifo_push_s),
        .pop_i     (pop_s),
        .wr_data_i (fifo_wr_data_s),
        .rd_data_o (fifo_rd_data_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    assign {packet_out, src_out, id_out} = fifo_rd_data_s;
    assign out_valid = ~fifo_empty_s;

endmodule
